// File: rtl/noc_run_ctrl_pkg.sv
// noc_run_ctrl_pkg: shared definitions for the NoC run controller.
//   - default timestamp width (the `TIME_WIDTH macro, overridable at compile time)
//   - run-state encodings, which are visible to software on the run_state output
`ifndef TIME_WIDTH
`define TIME_WIDTH 16
`endif

package noc_run_ctrl_pkg;

  localparam int TIME_WIDTH_DEF = `TIME_WIDTH;

  typedef enum logic [2:0] {
    RUN_IDLE    = 3'd0,
    RUN_RUN     = 3'd1,
    RUN_PAUSE   = 3'd2,
    RUN_DONE    = 3'd3,
    RUN_TIMEOUT = 3'd4
  } run_state_e;

endpackage

// File: rtl/noc_popcount.sv
// noc_popcount: combinational count of set bits in a NUM_NODES-wide vector.
// Ports:
//   bits_i   [NUM_NODES-1:0]  input vector
//   count_o  [FC_WIDTH-1:0]   number of ones in bits_i
module noc_popcount #(
  parameter int NUM_NODES = 16,
  parameter int FC_WIDTH  = $clog2(NUM_NODES + 1)
) (
  input  logic [NUM_NODES-1:0] bits_i,
  output logic [FC_WIDTH-1:0]  count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      count_o = count_o + FC_WIDTH'(bits_i[i]);
    end
  end

endmodule

// File: rtl/noc_run_ctrl.sv
// noc_run_ctrl: run controller and timestamp source for an N-node mesh NoC.
// Gates traffic cores through enable_global, ends the run once every node
// reports completion, and provides a Gray timestamp plus a binary cycle count.
//
// state   | meaning
// IDLE    | waiting for enable_wire; cores gated off
// RUN     | cores enabled, counters and stall watchdog advancing
// PAUSE   | host dropped enable_wire; counters and watchdog frozen
// DONE    | all selected finish flags seen; terminal until clear/reset
// TIMEOUT | no finish progress for timeout_limit cycles; terminal
//
// Ports:
//   clk_global, rst_n (async, active-low)
//   enable_wire      run request from host/pad
//   packet_side_en   1 = pkt_finish flags, 0 = flit_finish flags
//   clear            synchronous restart to IDLE
//   pkt_finish, flit_finish [NUM_NODES]  per-node finish levels
//   timeout_limit    stall cycles allowed, 0 disables the watchdog
//   enable_global    core enable (state == RUN)
//   counter_num      Gray-coded timestamp (one cycle behind bin_ts)
//   counter_out      binary enabled-cycle count
//   run_state        state encoding
//   finish_count     registered popcount of the selected flags
//   done_pulse       one-cycle pulse on entry to DONE
//   timeout_flag     high while in TIMEOUT
module noc_run_ctrl
  import noc_run_ctrl_pkg::*;
#(
  parameter int NUM_NODES  = 16,
  parameter int TIME_WIDTH = TIME_WIDTH_DEF,
  parameter int CNT_WIDTH  = 32,
  parameter int TO_WIDTH   = 24,
  parameter int FC_WIDTH   = $clog2(NUM_NODES + 1)
) (
  input  logic                  clk_global,
  input  logic                  rst_n,
  input  logic                  enable_wire,
  input  logic                  packet_side_en,
  input  logic                  clear,
  input  logic [NUM_NODES-1:0]  pkt_finish,
  input  logic [NUM_NODES-1:0]  flit_finish,
  input  logic [TO_WIDTH-1:0]   timeout_limit,
  output logic                  enable_global,
  output logic [TIME_WIDTH-1:0] counter_num,
  output logic [CNT_WIDTH-1:0]  counter_out,
  output logic [2:0]            run_state,
  output logic [FC_WIDTH-1:0]   finish_count,
  output logic                  done_pulse,
  output logic                  timeout_flag
);

  run_state_e            state_q, state_d;
  logic                  mode_q;
  logic [TIME_WIDTH-1:0] bin_ts_q;
  logic [TIME_WIDTH-1:0] counter_num_q;
  logic [CNT_WIDTH-1:0]  counter_out_q;
  logic [FC_WIDTH-1:0]   finish_count_q;
  logic [FC_WIDTH-1:0]   fc_comb;
  logic [TO_WIDTH-1:0]   stall_q;
  logic                  done_pulse_q;

  logic                  mode_sel;
  logic [NUM_NODES-1:0]  sel;
  logic                  all_done;
  logic                  timeout_hit;
  logic                  run_en;

  // In IDLE the mode has not been latched yet, so the live select decides
  // whether the flags are already complete at the moment of enable.
  assign mode_sel    = (state_q == RUN_IDLE) ? packet_side_en : mode_q;
  assign sel         = mode_sel ? pkt_finish : flit_finish;
  assign all_done    = &sel;
  assign timeout_hit = (timeout_limit != '0) && (stall_q == timeout_limit);
  assign run_en      = (state_q == RUN_RUN);

  noc_popcount #(
    .NUM_NODES (NUM_NODES),
    .FC_WIDTH  (FC_WIDTH)
  ) u_popcount (
    .bits_i  (sel),
    .count_o (fc_comb)
  );

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = RUN_IDLE;
    end else begin
      case (state_q)
        RUN_IDLE: begin
          if (enable_wire) state_d = all_done ? RUN_DONE : RUN_RUN;
        end
        RUN_RUN: begin
          if (all_done)         state_d = RUN_DONE;
          else if (timeout_hit) state_d = RUN_TIMEOUT;
          else if (!enable_wire) state_d = RUN_PAUSE;
        end
        RUN_PAUSE: begin
          if (all_done)         state_d = RUN_DONE;
          else if (enable_wire) state_d = RUN_RUN;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_global or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN_IDLE;
      mode_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_pulse_q <= (state_d == RUN_DONE) && (state_q != RUN_DONE);
      if (!clear && (state_q == RUN_IDLE) && enable_wire) begin
        mode_q <= packet_side_en;
      end
    end
  end

  always_ff @(posedge clk_global or negedge rst_n) begin
    if (!rst_n) begin
      bin_ts_q       <= TIME_WIDTH'(1);
      counter_num_q  <= '0;
      counter_out_q  <= '0;
      finish_count_q <= '0;
    end else if (clear) begin
      bin_ts_q       <= TIME_WIDTH'(1);
      counter_num_q  <= '0;
      counter_out_q  <= '0;
      finish_count_q <= '0;
    end else begin
      counter_num_q  <= bin_ts_q ^ (bin_ts_q >> 1);
      finish_count_q <= fc_comb;
      if (run_en) begin
        bin_ts_q      <= bin_ts_q + TIME_WIDTH'(1);
        counter_out_q <= counter_out_q + CNT_WIDTH'(1);
      end
    end
  end

  // Watchdog counts RUN cycles without finish progress. A pause keeps the
  // accumulated value; any other exit from RUN starts the next run fresh.
  always_ff @(posedge clk_global or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (clear) begin
      stall_q <= '0;
    end else if (run_en) begin
      if ((state_d != RUN_RUN) && (state_d != RUN_PAUSE)) begin
        stall_q <= '0;
      end else if (fc_comb > finish_count_q) begin
        stall_q <= '0;
      end else if (stall_q != '1) begin
        stall_q <= stall_q + TO_WIDTH'(1);
      end
    end
  end

  assign enable_global = run_en;
  assign counter_num   = counter_num_q;
  assign counter_out   = counter_out_q;
  assign run_state     = state_q;
  assign finish_count  = finish_count_q;
  assign done_pulse    = done_pulse_q;
  assign timeout_flag  = (state_q == RUN_TIMEOUT);

endmodule

// File: tb/tb_noc_run_ctrl.sv
module tb_noc_run_ctrl;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3, S_TO = 4;

  logic        clk_global = 1'b0;
  logic        rst_n;
  logic        enable_wire;
  logic        packet_side_en;
  logic        clear;
  logic [15:0] pkt_finish;
  logic [15:0] flit_finish;
  logic [23:0] timeout_limit;

  logic        enable_global;
  logic [15:0] counter_num;
  logic [31:0] counter_out;
  logic [2:0]  run_state;
  logic [4:0]  finish_count;
  logic        done_pulse;
  logic        timeout_flag;

  logic        e4_enable_global;
  logic [3:0]  e4_counter_num;
  logic [31:0] e4_counter_out;
  logic [2:0]  e4_run_state;
  logic [4:0]  e4_finish_count;
  logic        e4_done_pulse;
  logic        e4_timeout_flag;

  int errors = 0;
  int checks = 0;

  always #5 clk_global = ~clk_global;

  noc_run_ctrl dut (
    .clk_global     (clk_global),
    .rst_n          (rst_n),
    .enable_wire    (enable_wire),
    .packet_side_en (packet_side_en),
    .clear          (clear),
    .pkt_finish     (pkt_finish),
    .flit_finish    (flit_finish),
    .timeout_limit  (timeout_limit),
    .enable_global  (enable_global),
    .counter_num    (counter_num),
    .counter_out    (counter_out),
    .run_state      (run_state),
    .finish_count   (finish_count),
    .done_pulse     (done_pulse),
    .timeout_flag   (timeout_flag)
  );

  noc_run_ctrl #(.TIME_WIDTH(4)) dut4 (
    .clk_global     (clk_global),
    .rst_n          (rst_n),
    .enable_wire    (enable_wire),
    .packet_side_en (packet_side_en),
    .clear          (clear),
    .pkt_finish     (pkt_finish),
    .flit_finish    (flit_finish),
    .timeout_limit  (timeout_limit),
    .enable_global  (e4_enable_global),
    .counter_num    (e4_counter_num),
    .counter_out    (e4_counter_out),
    .run_state      (e4_run_state),
    .finish_count   (e4_finish_count),
    .done_pulse     (e4_done_pulse),
    .timeout_flag   (e4_timeout_flag)
  );

  // Behavioural reference: one update per clock edge from the run rules.
  int          m_state;
  bit          m_mode;
  logic [15:0] m_bin;
  logic [15:0] m_gray;
  logic [31:0] m_cnt;
  int          m_fc;
  int          m_stall;
  bit          m_dp;

  always @(posedge clk_global or negedge rst_n) begin
    logic [15:0] s;
    bit          ad;
    int          pc;
    int          ns;
    if (!rst_n) begin
      m_state <= S_IDLE; m_mode <= 0; m_bin <= 16'd1; m_gray <= 0;
      m_cnt <= 0; m_fc <= 0; m_stall <= 0; m_dp <= 0;
    end else begin
      s  = (((m_state == S_IDLE) ? packet_side_en : m_mode) != 0) ? pkt_finish : flit_finish;
      ad = (s == 16'hFFFF);
      pc = $countones(s);
      ns = m_state;
      if (clear) ns = S_IDLE;
      else if (m_state == S_IDLE && enable_wire) ns = ad ? S_DONE : S_RUN;
      else if ((m_state == S_RUN || m_state == S_PAUSE) && ad) ns = S_DONE;
      else if (m_state == S_RUN && timeout_limit != 0 && m_stall == int'(timeout_limit)) ns = S_TO;
      else if (m_state == S_RUN && !enable_wire) ns = S_PAUSE;
      else if (m_state == S_PAUSE && enable_wire) ns = S_RUN;
      m_state <= ns;
      m_dp    <= !clear && ns == S_DONE && m_state != S_DONE;
      if (!clear && m_state == S_IDLE && enable_wire) m_mode <= packet_side_en;
      if (clear) begin
        m_bin <= 16'd1; m_gray <= 0; m_cnt <= 0; m_fc <= 0; m_stall <= 0;
      end else begin
        m_gray <= m_bin ^ (m_bin >> 1);
        m_fc   <= pc;
        if (m_state == S_RUN) begin
          m_bin <= m_bin + 16'd1;
          m_cnt <= m_cnt + 32'd1;
          if (ns != S_RUN && ns != S_PAUSE) m_stall <= 0;
          else if (pc > m_fc) m_stall <= 0;
          else if (m_stall < 24'hFFFFFF) m_stall <= m_stall + 1;
        end
      end
    end
  end

  logic [58:0] obs, expv;
  assign obs  = {run_state, enable_global, done_pulse, timeout_flag, finish_count, counter_num, counter_out};
  assign expv = {3'(m_state), m_state == S_RUN, m_dp, m_state == S_TO, 5'(m_fc), m_gray, m_cnt};

  task automatic tick();
    @(posedge clk_global);
    #1;
  endtask

  task automatic do_clear();
    clear = 1; enable_wire = 0; pkt_finish = 0; flit_finish = 0;
    tick();
    clear = 0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0; enable_wire = 0; packet_side_en = 0; clear = 0;
    pkt_finish = 0; flit_finish = 0; timeout_limit = 0;
    repeat (3) tick();
    checks++;
    if ({run_state, enable_global, counter_num, counter_out, finish_count, done_pulse, timeout_flag} !== 59'd0) begin
      errors++;
      $display("FAIL reset_values: got st=%0d en=%0b num=%h cnt=%0d fc=%0d dp=%0b to=%0b want all zero",
               run_state, enable_global, counter_num, counter_out, finish_count, done_pulse, timeout_flag);
    end
    rst_n = 1;
    tick();
    checks++;
    if (counter_num !== 16'h0001 || run_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_first_update: got num=%h st=%0d want num=0001 st=0", counter_num, run_state);
    end
  endtask

  task automatic test_basic_run();
    do_clear();
    packet_side_en = 0; timeout_limit = 0;
    enable_wire = 1;
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (enable_global !== 1'b1) begin
        errors++; $display("FAIL basic_enable cyc%0d: got %0b want 1", i, enable_global);
      end
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL basic_model cyc%0d: got %h want %h", i, obs, expv);
      end
      if (i < 9) tick();
    end
    flit_finish = 16'hFFFF;
    tick();
    checks++;
    if (run_state !== 3'd3 || counter_out !== 32'd10 || done_pulse !== 1'b1 || enable_global !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got st=%0d cnt=%0d dp=%0b en=%0b want st=3 cnt=10 dp=1 en=0",
               run_state, counter_out, done_pulse, enable_global);
    end
    tick();
    checks++;
    if (counter_num !== 16'h000E || done_pulse !== 1'b0 || run_state !== 3'd3) begin
      errors++;
      $display("FAIL basic_gray: got num=%h dp=%0b st=%0d want num=000e dp=0 st=3", counter_num, done_pulse, run_state);
    end
  endtask

  task automatic test_mode_latch();
    logic [15:0] p;
    do_clear();
    p = 16'($urandom) & ~(16'd1 << $urandom_range(15, 0));
    packet_side_en = 1; pkt_finish = p; enable_wire = 1;
    tick();
    packet_side_en = 0; flit_finish = 16'hFFFF;
    repeat (4) begin
      tick();
      checks++;
      if (run_state !== 3'd1 || finish_count !== 5'($countones(p))) begin
        errors++;
        $display("FAIL mode_hold: got st=%0d fc=%0d want st=1 fc=%0d", run_state, finish_count, $countones(p));
      end
    end
    pkt_finish = 16'hFFFF;
    tick();
    checks++;
    if (run_state !== 3'd3 || obs !== expv) begin
      errors++; $display("FAIL mode_done: got st=%0d obs=%h want st=3 obs=%h", run_state, obs, expv);
    end
  endtask

  task automatic test_pause_resume();
    int k, j;
    do_clear();
    k = $urandom_range(10, 2); j = $urandom_range(10, 2);
    enable_wire = 1;
    tick();
    repeat (k) tick();
    enable_wire = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (run_state !== 3'd2 || counter_out !== 32'(k + 1) || enable_global !== 1'b0) begin
        errors++;
        $display("FAIL pause_frozen cyc%0d: got st=%0d cnt=%0d want st=2 cnt=%0d", i, run_state, counter_out, k + 1);
      end
    end
    enable_wire = 1;
    tick();
    repeat (j) tick();
    checks++;
    if (counter_out !== 32'(k + 1 + j) || obs !== expv) begin
      errors++;
      $display("FAIL pause_resume_count: got cnt=%0d obs=%h want cnt=%0d obs=%h", counter_out, obs, k + 1 + j, expv);
    end
  endtask

  task automatic test_watchdog();
    logic [15:0] f;
    do_clear();
    f = 0;
    while ($countones(f) < 3) f[$urandom_range(15, 0)] = 1'b1;
    flit_finish = f; packet_side_en = 0; timeout_limit = 24'd8;
    tick();
    enable_wire = 1;
    tick();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (run_state !== 3'd1 || finish_count !== 5'd3) begin
        errors++; $display("FAIL wd_running cyc%0d: got st=%0d fc=%0d want st=1 fc=3", i, run_state, finish_count);
      end
      tick();
    end
    checks++;
    if (run_state !== 3'd4 || timeout_flag !== 1'b1 || enable_global !== 1'b0) begin
      errors++;
      $display("FAIL wd_timeout: got st=%0d to=%0b en=%0b want st=4 to=1 en=0", run_state, timeout_flag, enable_global);
    end
    do_clear();
    flit_finish = f; timeout_limit = 0; enable_wire = 1;
    repeat (40) tick();
    checks++;
    if (run_state !== 3'd1 || timeout_flag !== 1'b0 || obs !== expv) begin
      errors++;
      $display("FAIL wd_disabled: got st=%0d to=%0b want st=1 to=0", run_state, timeout_flag);
    end
  endtask

  task automatic test_edge_cases();
    do_clear();
    packet_side_en = 0; flit_finish = 16'hFFFF;
    tick();
    checks++;
    if (run_state !== 3'd0 || finish_count !== 5'd16) begin
      errors++; $display("FAIL edge_idle_wait: got st=%0d fc=%0d want st=0 fc=16", run_state, finish_count);
    end
    enable_wire = 1;
    tick();
    checks++;
    if (run_state !== 3'd3 || enable_global !== 1'b0 || done_pulse !== 1'b1) begin
      errors++;
      $display("FAIL edge_direct_done: got st=%0d en=%0b dp=%0b want st=3 en=0 dp=1", run_state, enable_global, done_pulse);
    end
    flit_finish = 0;
    repeat (3) tick();
    checks++;
    if (run_state !== 3'd3 || enable_global !== 1'b0) begin
      errors++; $display("FAIL edge_flags_drop: got st=%0d en=%0b want st=3 en=0", run_state, enable_global);
    end
    do_clear();
    enable_wire = 1;
    repeat (5) tick();
    flit_finish = 16'hFFFF; clear = 1;
    tick();
    checks++;
    if (run_state !== 3'd0 || counter_out !== 32'd0 || done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL edge_clear_vs_done: got st=%0d cnt=%0d dp=%0b want st=0 cnt=0 dp=0", run_state, counter_out, done_pulse);
    end
    clear = 0; enable_wire = 0; flit_finish = 0;
  endtask

  task automatic test_wrap();
    do_clear();
    timeout_limit = 0; enable_wire = 1;
    tick();
    repeat (19) tick();
    enable_wire = 0;
    tick();
    checks++;
    if (e4_counter_out !== 32'd20 || counter_out !== 32'd20) begin
      errors++; $display("FAIL wrap_count: got w4=%0d w16=%0d want 20", e4_counter_out, counter_out);
    end
    tick();
    checks++;
    if (e4_counter_num !== 4'h7 || counter_num !== 16'h001F) begin
      errors++; $display("FAIL wrap_gray: got w4=%h w16=%h want 7 / 001f", e4_counter_num, counter_num);
    end
  endtask

  task automatic test_random();
    do_clear();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(39, 0) == 0) begin
        clear = 1; pkt_finish = 0; flit_finish = 0;
        timeout_limit = 24'($urandom_range(12, 0));
      end else begin
        clear = 0;
      end
      enable_wire = ($urandom_range(99, 0) < 85);
      if ($urandom_range(9, 0) == 0) packet_side_en = ~packet_side_en;
      if ($urandom_range(2, 0) != 0) begin
        if ($urandom_range(9, 0) < 7) pkt_finish[$urandom_range(15, 0)] = 1'b1;
        else pkt_finish[$urandom_range(15, 0)] = 1'b0;
      end
      if ($urandom_range(2, 0) != 0) begin
        if ($urandom_range(9, 0) < 7) flit_finish[$urandom_range(15, 0)] = 1'b1;
        else flit_finish[$urandom_range(15, 0)] = 1'b0;
      end
      tick();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL random_model cyc%0d: got %h want %h", c, obs, expv);
      end
    end
    clear = 0;
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_mode_latch();
    test_pause_resume();
    test_watchdog();
    test_edge_cases();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
